writeback_seq: RTL and testbench
================================

# writeback_seq

Write-back sequencer for the multicycle core's register-file write port. On a start pulse from the main control FSM it drives the write-register mux selector, the write-data mux selector and the register-file write enable for one or two consecutive write cycles, then pulses done. It handles single writes (R-type, I-type, load, JAL, PUSH) and the two-write POP (rt, then $sp), and suppresses writes to $0.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- op  in  3  write-back operation, latched on an accepted start.
- rt_idx  in  5  instruction rt field, latched on an accepted start.
- rd_idx  in  5  instruction rd field, latched on an accepted start.
- hold  in  1  write port borrowed elsewhere; stalls the current write cycle.
- writereg_sel  out  4  write-register mux select: 0=rt, 1=rd, 2=$31, 3=$29.
- memtoreg_sel  out  4  write-data mux select: 0=ALUOut, 1=MDR, 2=PC.
- reg_write  out  1  register-file write enable.
- busy  out  1  sequence in progress (states W1, W2).
- done  out  1  one-cycle completion pulse.
- err  out  1  illegal op flag, valid with done.

## Operation
- States: IDLE, W1, W2, DONE. Reset and idle state is IDLE.
- Op table, giving first write (dest, data) and optional second write:
  - 0 RTYPE: (rd, ALUOut).
  - 1 ITYPE: (rt, ALUOut).
  - 2 LOAD: (rt, MDR).
  - 3 JAL: ($31, PC).
  - 4 PUSH: ($29, ALUOut).
  - 5 POP: (rt, MDR), then ($29, ALUOut).
  - 6, 7: illegal.
- IDLE or DONE with start=1:
  - Latch op, rt_idx and rd_idx, then go to W1.
  - Illegal op goes directly to DONE with err=1 and no write cycle.
- W1:
  - Drive the first-write selectors.
  - hold=1: stay in W1.
  - Otherwise, if op=POP go to W2, else go to DONE.
- W2 (POP only): drive writereg_sel=3 and memtoreg_sel=0. hold=1 stays in W2; otherwise go to DONE.
- DONE: done=1 for exactly one cycle, busy=0. The next state is IDLE, or W1 if start=1 (back-to-back).
- reg_write = (state is W1 or W2) & ~hold & ~zero_dest.
  - zero_dest is 1 when the resolved destination index is 0 (rd for RTYPE; rt for ITYPE, LOAD and the first POP write).
  - $31 and $29 are never zero.
  - A suppressed write still consumes its cycle.
- Selector outputs are decoded from the registered state and latched op. They stay stable for the whole W1/W2 cycle, including hold cycles. In IDLE and DONE both selectors are 0.
- err is 1 only in the DONE cycle of an illegal op; it is 0 otherwise.
- start while busy=1 is ignored and not queued. op, rt_idx and rd_idx changes while busy are ignored.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, writereg_sel=0, memtoreg_sel=0, reg_write=0, busy=0, done=0, err=0, latched fields cleared. Deasserting mid-sequence aborts with no further writes.
- start sampled at edge k: W1 occupies cycle k..k+1, with reg_write high and the write committing at edge k+1.
- Single write: done in cycle k+1..k+2.
- POP: W2 write commits at edge k+2, and done is in cycle k+2..k+3.
- Each hold cycle adds one cycle of latency. reg_write responds combinationally to hold within the same cycle.
- Illegal op: done=1 and err=1 in cycle k..k+1, with zero write cycles.
- Minimum start-to-start interval: 2 cycles for a single write, 3 for POP (start accepted during DONE).

## Test plan
- Reset mid-POP: assert reset_n=0 while in W2 -> all outputs go to 0 immediately; after release, no reg_write until the next start.
- RTYPE with rd_idx=8 -> one cycle with writereg_sel=1, memtoreg_sel=0, reg_write=1; done one cycle later; busy high exactly 1 cycle.
- POP with rt_idx=5 and hold=1 during the first W2 cycle:
  - Cycle 1: (sel 0, MDR, we=1).
  - Cycle 2: (sel 3, ALUOut, we=0).
  - Cycle 3: (sel 3, we=1).
  - Then done.
- LOAD with rt_idx=0 -> busy for 1 cycle with reg_write=0 throughout; done pulses, err=0.
- JAL followed by start for ITYPE during DONE:
  - JAL: writereg_sel=2, memtoreg_sel=2.
  - ITYPE accepted and its W1 (sel 0, we=1) follows with no idle cycle.
  - A start asserted during JAL's W1 is ignored.
- op=6 -> no reg_write; done=1 and err=1 in the cycle after start; err=0 after the next legal start.

Source files
------------

// File: rtl/writeback_seq.sv
// writeback_seq: sequences one or two register-file write cycles per start, with $0 write suppression
module writeback_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [4:0] rt_idx,
  input  logic [4:0] rd_idx,
  input  logic       hold,
  output logic [3:0] writereg_sel,
  output logic [3:0] memtoreg_sel,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam logic [1:0] IDLE = 2'd0, W1 = 2'd1, W2 = 2'd2, DONE = 2'd3;
  localparam logic [2:0] RTYPE = 3'd0, ITYPE = 3'd1, LOAD = 3'd2, JAL = 3'd3, PUSH = 3'd4, POP = 3'd5;
  logic [1:0] state, nxt;
  logic [2:0] op_q;
  logic [4:0] rt_q, rd_q;
  logic       accept, illegal, zero_dest;
  logic [3:0] ws1, ms1;
  assign accept  = start & ~busy;
  assign illegal = op[2] & op[1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      op_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= op;
      rt_q <= rt_idx;
      rd_q <= rd_idx;
    end
  always_comb begin
    nxt = accept ? (illegal ? DONE : W1) :
          state == W1 ? (hold ? W1 : (op_q == POP ? W2 : DONE)) :
          state == W2 ? (hold ? W2 : DONE) : IDLE;
  end
  always_comb begin
    ws1 = op_q == RTYPE ? 4'd1 : op_q == JAL ? 4'd2 : op_q == PUSH ? 4'd3 : 4'd0;
    ms1 = (op_q == LOAD || op_q == POP) ? 4'd1 : op_q == JAL ? 4'd2 : 4'd0;
    zero_dest = op_q == RTYPE ? rd_q == 5'd0 :
                (op_q == ITYPE || op_q == LOAD || op_q == POP) && rt_q == 5'd0;
    busy = state == W1 || state == W2;
    done = state == DONE;
    err = done & op_q[2] & op_q[1];
    writereg_sel = state == W1 ? ws1 : state == W2 ? 4'd3 : 4'd0;
    memtoreg_sel = state == W1 ? ms1 : 4'd0;
    reg_write = (state == W2 || (state == W1 && !zero_dest)) && !hold;
  end
endmodule

// File: tb/tb_writeback_seq.sv
// tb_writeback_seq: directed vectors with hand-computed expected outputs for writeback_seq
module tb_writeback_seq;
  logic       clk = 0;
  logic       reset_n = 0;
  logic       start = 0;
  logic [2:0] op = 0;
  logic [4:0] rt_idx = 0, rd_idx = 0;
  logic       hold = 0;
  logic [3:0] writereg_sel, memtoreg_sel;
  logic       reg_write, busy, done, err;
  int errors = 0, checks = 0;

  writeback_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rt_idx(rt_idx),
    .rd_idx(rd_idx), .hold(hold), .writereg_sel(writereg_sel),
    .memtoreg_sel(memtoreg_sel), .reg_write(reg_write), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ex(input logic [3:0] ws, input logic [3:0] ms,
                                     input logic we, input logic b, input logic d, input logic e);
    return {ws, ms, we, b, d, e};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ws=%0d ms=%0d we=%b busy=%b done=%b err=%b, want ws=%0d ms=%0d we=%b busy=%b done=%b err=%b",
               tag, got[11:8], got[7:4], got[3], got[2], got[1], got[0],
               exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [11:0] obs();
    return {writereg_sel, memtoreg_sel, reg_write, busy, done, err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3 chk("reset", obs(), ex(0, 0, 0, 0, 0, 0));
    cyc(); cyc();
    reset_n = 1;
    #1 chk("idle_after_reset", obs(), ex(0, 0, 0, 0, 0, 0));

    start = 1; op = 0; rd_idx = 8; rt_idx = 3;
    cyc(); start = 0; rd_idx = 0;
    #1 chk("rtype_w1", obs(), ex(1, 0, 1, 1, 0, 0));
    cyc(); #1 chk("rtype_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc(); #1 chk("rtype_idle", obs(), ex(0, 0, 0, 0, 0, 0));

    start = 1; op = 5; rt_idx = 5;
    cyc(); start = 0; op = 0; rt_idx = 0;
    #1 chk("pop_w1", obs(), ex(0, 1, 1, 1, 0, 0));
    cyc(); hold = 1;
    #1 chk("pop_w2_hold", obs(), ex(3, 0, 0, 1, 0, 0));
    cyc(); hold = 0;
    #1 chk("pop_w2", obs(), ex(3, 0, 1, 1, 0, 0));
    cyc(); #1 chk("pop_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc(); #1 chk("pop_idle", obs(), ex(0, 0, 0, 0, 0, 0));

    start = 1; op = 2; rt_idx = 0;
    cyc(); start = 0;
    #1 chk("load_r0_w1", obs(), ex(0, 1, 0, 1, 0, 0));
    cyc(); #1 chk("load_r0_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc(); #1 chk("load_r0_idle", obs(), ex(0, 0, 0, 0, 0, 0));

    start = 1; op = 3;
    cyc(); op = 1; rt_idx = 7;
    #1 chk("jal_w1", obs(), ex(2, 2, 1, 1, 0, 0));
    cyc(); #1 chk("jal_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc(); start = 0;
    #1 chk("itype_b2b_w1", obs(), ex(0, 0, 1, 1, 0, 0));
    cyc(); #1 chk("itype_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc(); #1 chk("itype_idle", obs(), ex(0, 0, 0, 0, 0, 0));

    start = 1; op = 6;
    cyc(); start = 0;
    #1 chk("illegal_done", obs(), ex(0, 0, 0, 0, 1, 1));
    cyc(); #1 chk("illegal_idle", obs(), ex(0, 0, 0, 0, 0, 0));
    start = 1; op = 1; rt_idx = 4;
    cyc(); start = 0;
    #1 chk("legal_after_illegal_w1", obs(), ex(0, 0, 1, 1, 0, 0));
    cyc(); #1 chk("legal_after_illegal_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc();

    start = 1; op = 4;
    cyc(); start = 0; hold = 1;
    #1 chk("push_w1_hold", obs(), ex(3, 0, 0, 1, 0, 0));
    cyc(); hold = 0;
    #1 chk("push_w1", obs(), ex(3, 0, 1, 1, 0, 0));
    cyc(); #1 chk("push_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc();

    start = 1; op = 0; rd_idx = 0;
    cyc(); start = 0;
    #1 chk("rtype_r0_w1", obs(), ex(1, 0, 0, 1, 0, 0));
    cyc(); #1 chk("rtype_r0_done", obs(), ex(0, 0, 0, 0, 1, 0));

    start = 1; op = 7;
    cyc(); op = 0; rd_idx = 9;
    #1 chk("op7_b2b_done", obs(), ex(0, 0, 0, 0, 1, 1));
    cyc(); start = 0;
    #1 chk("rtype_after_op7_w1", obs(), ex(1, 0, 1, 1, 0, 0));
    cyc(); #1 chk("rtype_after_op7_done", obs(), ex(0, 0, 0, 0, 1, 0));
    cyc();

    start = 1; op = 5; rt_idx = 5;
    cyc(); start = 0;
    #1 chk("rstpop_w1", obs(), ex(0, 1, 1, 1, 0, 0));
    cyc(); #1 chk("rstpop_w2", obs(), ex(3, 0, 1, 1, 0, 0));
    #1 reset_n = 0;
    #1 chk("rstpop_async", obs(), ex(0, 0, 0, 0, 0, 0));
    cyc(); reset_n = 1;
    #1 chk("rstpop_release", obs(), ex(0, 0, 0, 0, 0, 0));
    cyc(); #1 chk("rstpop_idle", obs(), ex(0, 0, 0, 0, 0, 0));
    cyc(); #1 chk("rstpop_idle2", obs(), ex(0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
